vga_pixel_gen: RTL and testbench
================================

# vga_pixel_gen

Downstream stage of the VGA timing controller: consumes its raw timing (hsync, vsync, video_on, curr_x, curr_y) and produces the 12-bit Basys3 RGB pixel stream plus re-aligned sync signals. It maps screen coordinates onto an integer-scaled image stored in a synchronous block ROM outside this module and fills the rest of the active area with a background colour. Sync signals are delayed through the same pipeline as the pixel data, so the outputs drive the VGA connector pins directly.

## Interface
- IMG_W, 128: image width in ROM pixels
- IMG_H, 96: image height in ROM pixels
- SCALE, 2: log2 of the integer upscale factor (each ROM pixel covers 2^SCALE × 2^SCALE screen pixels)
- X0, 64: screen x of the image's left edge
- Y0, 48: screen y of the image's top edge
- ADDR_W, 14: ROM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W
- BG_COLOR, 12'h000: RGB444 colour for active pixels outside the image
- clk  in  1  pixel clock (same clock as the timing controller)
- reset  in  1  asynchronous, active-high reset
- hsync_in  in  1  active-low hsync from the timing controller
- vsync_in  in  1  active-low vsync from the timing controller
- video_on  in  1  high inside the 640×480 active area
- curr_x  in  10  current horizontal count
- curr_y  in  10  current vertical count
- rom_addr  out  ADDR_W  ROM read address, row-major
- rom_data  in  12  ROM read data, RGB444 {R[3:0],G[3:0],B[3:0]}; valid one clock after rom_addr
- hsync  out  1  delayed active-low hsync
- vsync  out  1  delayed active-low vsync
- rgb  out  12  pixel colour

## Operation
- Image window: curr_x in [X0, X0+(IMG_W<<SCALE)) and curr_y in [Y0, Y0+(IMG_H<<SCALE)). Compare in 11-bit unsigned arithmetic so the window edge cannot wrap.
- x_img = (curr_x−X0)>>SCALE; y_img = (curr_y−Y0)>>SCALE; address = y_img*IMG_W + x_img, truncated to ADDR_W. Multiply by a constant only; no divider.
- Pipeline:
  - S1 registers rom_addr, in_img = window & video_on, vid = video_on, and the two syncs.
  - The ROM registers its data.
  - S2 carries in_img, vid and the syncs alongside the ROM stage.
  - S3 (output register) sets rgb = in_img ? rom_data : (vid ? BG_COLOR : 12'h000).
- Outside the window, rom_addr holds the last computed in-window value or 0. Its value there is don't-care, but it must never go X.
- Blanking (video_on=0) always outputs black, even when the coordinates fall inside the window range.
- No internal state beyond the pipeline. The block runs every clock, with no enable and no stall.

## Timing
- Inputs presented in cycle n:
  - rom_addr is valid in cycle n+1.
  - rom_data is consumed in cycle n+2.
  - rgb, hsync and vsync are valid in cycle n+3.
  - Total latency is exactly 3 cycles, identical for pixel and syncs.
- Reset (asynchronous, active-high) clears all pipeline stages:
  - hsync=1, vsync=1, rgb=0, rom_addr=0.
  - Sync and vid pipeline bits reset to 1, 1 and 0.
- Reset mid-frame: outputs take their reset values immediately. After release, the first 3 cycles output reset values while the pipeline refills; then the outputs track the inputs with 3-cycle latency. No frame resynchronisation is needed.
- Frame and line wrap (curr_x 799→0, curr_y 524→0) need no special handling; the addressing is purely a function of the coordinates.

## Configuration
- PIXEL_GEN_TESTPAT_EN:
  - Defined: adds input port test_mode (1 bit). When test_mode=1, the active-area colour is SMPTE-style bars over eight 80-pixel-wide columns, by curr_x: 0–79 FFF, 80–159 FF0, 160–239 0FF, 240–319 0F0, 320–399 F0F, 400–479 F00, 480–559 00F, 560–639 000.
  - Defined, bar behaviour: the ROM output is ignored. Blanking is still black. Latency is still 3. Bar selection uses comparators, not division. test_mode is sampled in S1 with the coordinates.
  - Undefined: no test_mode port and no bar logic.

## Test plan
- Reset: assert reset mid-line → hsync=1, vsync=1, rgb=000, rom_addr=0 immediately; after release, the first valid pixel appears 3 cycles after the first post-reset input.
- Address mapping (defaults), ROM model returns data = addr[11:0]:
  - (x=64, y=48) → rom_addr 0.
  - (x=67, y=51) → 0.
  - (x=68, y=48) → 1.
  - (x=64, y=52) → 128.
  - (x=575, y=431) → 12287.
  - In each case rgb equals the model data 3 cycles later.
- Window edges: x=63 or x=576, and y=47 or y=432, with video_on=1 → rgb=BG_COLOR. The same coordinates with video_on=0 → rgb=000.
- Sync alignment: drive a full 800×525 frame from a timing-controller model → hsync/vsync output edges occur exactly 3 cycles after the input edges; rgb=000 whenever the delayed video_on=0.
- Non-default geometry (IMG_W=160, IMG_H=120, SCALE=2, X0=Y0=0): a whole frame is image with no background; (639,479) → rom_addr 19199.
- With PIXEL_GEN_TESTPAT_EN and test_mode=1:
  - x=0 → FFF.
  - x=79 → FFF.
  - x=80 → FF0.
  - x=400 → F00.
  - x=639 → 000.
  - In each case the output is independent of rom_data.

Source files
------------

// File: rtl/vga_pixel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pixel_gen: maps VGA timing coordinates onto an upscaled ROM image and |
// | emits RGB444 with syncs re-aligned through a 3-stage pipeline.            |
// | Optional macro PIXEL_GEN_TESTPAT_EN adds test_mode colour bars.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_pixel_gen #(
  parameter int          IMG_W    = 128,
  parameter int          IMG_H    = 96,
  parameter int          SCALE    = 2,
  parameter int          X0       = 64,
  parameter int          Y0       = 48,
  parameter int          ADDR_W   = 14,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on,
  input  logic [9:0]        curr_x,
  input  logic [9:0]        curr_y,
`ifdef PIXEL_GEN_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       rgb
);

  localparam logic [10:0] X_HI = 11'(X0 + (IMG_W << SCALE));
  localparam logic [10:0] Y_HI = 11'(Y0 + (IMG_H << SCALE));

  // Subtract with one spare bit: the borrow doubles as the lower-edge compare.
  logic [11:0]       dx, dy;
  logic [10:0]       x_img, y_img;
  logic              window;
  logic [ADDR_W-1:0] addr_next;

  assign dx        = {2'b00, curr_x} - 12'(X0);
  assign dy        = {2'b00, curr_y} - 12'(Y0);
  assign x_img     = dx[10:0] >> SCALE;
  assign y_img     = dy[10:0] >> SCALE;
  assign window    = !dx[11] && ({1'b0, curr_x} < X_HI) &&
                     !dy[11] && ({1'b0, curr_y} < Y_HI);
  assign addr_next = ADDR_W'(y_img) * ADDR_W'(IMG_W) + ADDR_W'(x_img);

  logic s1_in_img, s1_vid, s1_hs, s1_vs;
  logic s2_in_img, s2_vid, s2_hs, s2_vs;
  logic [11:0] pix;

`ifdef PIXEL_GEN_TESTPAT_EN
  logic [11:0] bar;
  logic [11:0] s1_bar, s2_bar;
  logic        s1_tm, s2_tm;

  always_comb begin
    bar = 12'h000;
    if      (curr_x < 10'd80)  bar = 12'hFFF;
    else if (curr_x < 10'd160) bar = 12'hFF0;
    else if (curr_x < 10'd240) bar = 12'h0FF;
    else if (curr_x < 10'd320) bar = 12'h0F0;
    else if (curr_x < 10'd400) bar = 12'hF0F;
    else if (curr_x < 10'd480) bar = 12'hF00;
    else if (curr_x < 10'd560) bar = 12'h00F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_bar <= 12'h000;
      s1_tm  <= 1'b0;
      s2_bar <= 12'h000;
      s2_tm  <= 1'b0;
    end else begin
      s1_bar <= bar;
      s1_tm  <= test_mode;
      s2_bar <= s1_bar;
      s2_tm  <= s1_tm;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      s1_in_img <= 1'b0;
      s1_vid    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s2_in_img <= 1'b0;
      s2_vid    <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      rgb       <= 12'h000;
    end else begin
      if (window) rom_addr <= addr_next;
      s1_in_img <= window & video_on;
      s1_vid    <= video_on;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s2_in_img <= s1_in_img;
      s2_vid    <= s1_vid;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      hsync     <= s2_hs;
      vsync     <= s2_vs;
      rgb       <= pix;
    end
  end

  always_comb begin
    pix = 12'h000;
    if (s2_vid) begin
      if (s2_in_img) pix = rom_data;
      else           pix = BG_COLOR;
`ifdef PIXEL_GEN_TESTPAT_EN
      if (s2_tm)     pix = s2_bar;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for vga_pixel_gen: default geometry with a
// distinct background colour, plus a second full-screen-image instance.
module tb_vga_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, video_on;
  logic [9:0]  curr_x, curr_y;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic [14:0] rom_addr2;
  logic [11:0] rom_data2;
  logic        hsync2, vsync2;
  logic [11:0] rgb2;
`ifdef PIXEL_GEN_TESTPAT_EN
  logic        test_mode;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_gen #(
    .IMG_W(128), .IMG_H(96), .SCALE(2), .X0(64), .Y0(48), .ADDR_W(14), .BG_COLOR(12'h5A5)
  ) u_dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on(video_on), .curr_x(curr_x), .curr_y(curr_y),
`ifdef PIXEL_GEN_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  vga_pixel_gen #(
    .IMG_W(160), .IMG_H(120), .SCALE(2), .X0(0), .Y0(0), .ADDR_W(15), .BG_COLOR(12'h5A5)
  ) u_dut2 (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on(video_on), .curr_x(curr_x), .curr_y(curr_y),
`ifdef PIXEL_GEN_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .rom_addr(rom_addr2), .rom_data(rom_data2), .hsync(hsync2), .vsync(vsync2), .rgb(rgb2)
  );

  // ROM models: data = low 12 address bits, one-cycle read latency.
  always @(posedge clk) begin
    rom_data  <= rom_addr[11:0];
    rom_data2 <= rom_addr2[11:0];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit von);
    int a;
    if (!von) return 12'h000;
    if (x < 64 || x >= 576 || y < 48 || y >= 432) return 12'h5A5;
    a = ((y - 48) >> 2) * 128 + ((x - 64) >> 2);
    return a[11:0];
  endfunction

  task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                       input bit tm);
    curr_x   = 10'(x);
    curr_y   = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
`ifdef PIXEL_GEN_TESTPAT_EN
    test_mode = tm;
`endif
  endtask

  task automatic vec(input string tag, input int x, input int y, input bit von, input bit tm,
                     input logic [15:0] exp_addr, input bit chk_addr, input logic [11:0] exp_rgb);
    @(negedge clk);
    drive(x, y, von, 1'b1, 1'b1, tm);
    @(negedge clk);
    if (chk_addr) check({tag, ".addr"}, 16'(rom_addr), exp_addr);
    repeat (2) @(negedge clk);
    check({tag, ".rgb"}, 16'(rgb), 16'(exp_rgb));
  endtask

  task automatic vec2(input string tag, input int x, input int y, input bit von,
                      input logic [15:0] exp_addr, input logic [11:0] exp_rgb);
    @(negedge clk);
    drive(x, y, von, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check({tag, ".addr"}, 16'(rom_addr2), exp_addr);
    repeat (2) @(negedge clk);
    check({tag, ".rgb"}, 16'(rgb2), 16'(exp_rgb));
  endtask

  // Timing-controller model: 800x525 counts, hsync low 656..751, vsync low on lines 490..491.
  task automatic run_lines(input int y0, input int nlines);
    bit          q_hs[$];
    bit          q_vs[$];
    logic [11:0] q_rgb[$];
    int          total;
    int          x;
    int          y;
    bit          von, hs, vs;
    total = nlines * 800;
    x = 0;
    y = y0;
    for (int c = 0; c < total + 3; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("stream.hsync", 16'(hsync), 16'(q_hs.pop_front()));
        check("stream.vsync", 16'(vsync), 16'(q_vs.pop_front()));
        check("stream.rgb",   16'(rgb),   16'(q_rgb.pop_front()));
      end
      if (c < total) begin
        von = (x < 640) && (y < 480);
        hs  = !(x >= 656 && x < 752);
        vs  = !(y >= 490 && y < 492);
        drive(x, y, von, hs, vs, 1'b0);
        q_hs.push_back(hs);
        q_vs.push_back(vs);
        q_rgb.push_back(model_rgb(x, y, von));
        x++;
        if (x == 800) begin
          x = 0;
          y = (y + 1) % 525;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    #12;
    check("rst.hsync", 16'(hsync), 16'h0001);
    check("rst.vsync", 16'(vsync), 16'h0001);
    check("rst.rgb",   16'(rgb),   16'h0000);
    check("rst.addr",  16'(rom_addr), 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Address mapping and pixel data
    vec("a0",  64,  48, 1'b1, 1'b0, 16'd0,     1'b1, 12'h000);
    vec("a1",  67,  51, 1'b1, 1'b0, 16'd0,     1'b1, 12'h000);
    vec("a2",  68,  48, 1'b1, 1'b0, 16'd1,     1'b1, 12'h001);
    vec("a3",  64,  52, 1'b1, 1'b0, 16'd128,   1'b1, 12'h080);
    vec("a4", 575, 431, 1'b1, 1'b0, 16'd12287, 1'b1, 12'hFFF);

    // Window edges, active then blanked
    vec("e0",  63, 100, 1'b1, 1'b0, 16'd0, 1'b0, 12'h5A5);
    vec("e1", 576, 100, 1'b1, 1'b0, 16'd0, 1'b0, 12'h5A5);
    vec("e2", 100,  47, 1'b1, 1'b0, 16'd0, 1'b0, 12'h5A5);
    vec("e3", 100, 432, 1'b1, 1'b0, 16'd0, 1'b0, 12'h5A5);
    vec("e4",  63, 100, 1'b0, 1'b0, 16'd0, 1'b0, 12'h000);
    vec("e5", 576, 100, 1'b0, 1'b0, 16'd0, 1'b0, 12'h000);
    vec("e6", 100,  47, 1'b0, 1'b0, 16'd0, 1'b0, 12'h000);
    vec("e7", 100, 432, 1'b0, 1'b0, 16'd0, 1'b0, 12'h000);
    vec("e8",  64,  52, 1'b0, 1'b0, 16'd0, 1'b0, 12'h000);

    // Full-screen image geometry
    vec2("g0", 639, 479, 1'b1, 16'd19199, 12'hAFF);
    vec2("g1",   0,   0, 1'b1, 16'd0,     12'h000);
    vec2("g2", 320, 240, 1'b1, 16'd9680,  12'h5D0);
    vec2("g3", 639, 479, 1'b0, 16'd19199, 12'h000);

    // Mid-line reset and pipeline refill
    @(negedge clk);
    drive(64, 52, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("pre.rgb",   16'(rgb),   16'h0080);
    check("pre.hsync", 16'(hsync), 16'h0000);
    #2 reset = 1'b1;
    #1;
    check("mid.hsync", 16'(hsync), 16'h0001);
    check("mid.vsync", 16'(vsync), 16'h0001);
    check("mid.rgb",   16'(rgb),   16'h0000);
    check("mid.addr",  16'(rom_addr), 16'h0000);
    @(negedge clk);
    drive(68, 52, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("refill1.rgb",   16'(rgb),   16'h0000);
    check("refill1.hsync", 16'(hsync), 16'h0001);
    @(negedge clk);
    check("refill2.rgb",   16'(rgb),   16'h0000);
    check("refill2.hsync", 16'(hsync), 16'h0001);
    @(negedge clk);
    check("refill3.rgb",   16'(rgb),   16'h0081);
    check("refill3.hsync", 16'(hsync), 16'h0000);

`ifdef PIXEL_GEN_TESTPAT_EN
    vec("t0",   0, 100, 1'b1, 1'b1, 16'd0, 1'b0, 12'hFFF);
    vec("t1",  79, 100, 1'b1, 1'b1, 16'd0, 1'b0, 12'hFFF);
    vec("t2",  80, 100, 1'b1, 1'b1, 16'd0, 1'b0, 12'hFF0);
    vec("t3", 400, 100, 1'b1, 1'b1, 16'd0, 1'b0, 12'hF00);
    vec("t4", 639, 100, 1'b1, 1'b1, 16'd0, 1'b0, 12'h000);
    vec("t5", 400, 100, 1'b0, 1'b1, 16'd0, 1'b0, 12'h000);
`endif

    // Streamed timing: image bottom edge, vsync edges, frame wrap
    run_lines(430, 3);
    run_lines(489, 4);
    run_lines(524, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
